output_display_driver: RTL and testbench
========================================

// Module: output_display_driver
// PURPOSE
//  Downstream consumer of the computer's final_out / OUT register. On each OUT-register
//  load, converts the 8-bit value to 3 BCD digits with a sequential double-dabble FSM.
//  Also handles an optional sign, and time-multiplexes 4 common-anode 7-seg digits.
//  Display order, right to left: ones, tens, hundreds, sign.
// PARAMETERS
//  DATA_WIDTH  8     input value width (fixed at 8; the BCD range assumes it)
//  SCAN_DIV    1000  clocks each digit is lit; must be >= 2
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset        in   1   asynchronous, active-low reset
//  load_i       in   1   single-cycle strobe: the OUT register has latched a new value
//  data_i       in   8   value to display, sampled when load_i=1
//  signed_i     in   1   1 = treat data_i as two's complement; sampled with load_i
//  busy_o       out  1   conversion in progress
//  bcd_o        out  12  committed {hundreds,tens,ones} BCD of the magnitude
//  neg_o        out  1   committed sign; 1 = negative
//  an_o         out  4   digit enables, one-hot, active-low; bit0 = ones digit
//  seg_o        out  7   segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE, busy_o=0, bcd_o=0, neg_o=0, pending cleared,
//   prescaler=0, digit index=0, an_o=4'b1111, seg_o=7'h7F.
//  FSM states: IDLE, CONVERT, COMMIT.
//   IDLE, load_i=1 at edge E0:
//    - latch magnitude: data_i, or -data_i when signed_i=1 && data_i[7]
//    - latch sign; shift count=0; enter CONVERT
//   CONVERT, edges E1..E8 (one step per edge):
//    - add 3 to each BCD nibble >=5, then shift {bcd,mag} left by 1
//    - after the 8th step, enter COMMIT
//   COMMIT, edge E9:
//    - bcd_o and neg_o update together
//    - if pending: restart CONVERT with the pending value (its E0 = this edge)
//    - otherwise go to IDLE
//  busy_o=1 from after E0 through E9; busy_o=0 after E9 unless restarting.
//  Latency: load edge to bcd_o visible is 9 clocks.
//  load_i while CONVERT/COMMIT: value and signed_i stored in a one-deep pending slot.
//   Later loads overwrite it (last wins). No load is lost except overwritten pending ones.
//  Magnitude range: 0..255 unsigned, 0..128 signed. 8'h80 signed -> 128, neg=1.
//   Three digits always suffice; there is no overflow case.
//  bcd_o/neg_o hold the last committed value; they never show partial conversions.
//  Scan:
//   - prescaler counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and the digit index
//     advances 0->1->2->3->0
//   - an_o and seg_o are registered from the index and committed value, so they update
//     together (no ghosting)
//   - first edge after reset release drives an_o=1110 (digit 0)
//  Digit content:
//   - d0 = ones, always shown
//   - d1 = tens, blank if hundreds=0 and tens=0
//   - d2 = hundreds, blank if 0
//   - d3 = minus if neg_o, else blank
//  Segment codes (hex):
//   0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 blank=7F minus=3F
//  Reset mid-conversion: abort at once. Outputs take reset values; pending is dropped.
// TESTING
//  1 Hold reset low, then release -> during reset an_o=1111, seg_o=7F, bcd_o=000,
//    busy_o=0; first edge after release an_o=1110, seg_o=40.
//  2 load 8'd1 unsigned -> busy_o high 9 clocks; bcd_o=12'h001, neg_o=0;
//    scan d0 seg=79, d1/d2/d3 seg=7F.
//  3 load 8'hFF, signed_i=0 -> bcd_o=12'h255, neg_o=0;
//    load 8'hFF, signed_i=1 -> bcd_o=12'h001, neg_o=1, d3 seg=3F.
//  4 load 8'h80, signed_i=1 -> bcd_o=12'h128, neg_o=1.
//    Then load 8'd100 unsigned -> d1 seg=40 (zero not blanked under a nonzero hundreds).
//  5 load 42 at E0, load 7 at E3, load 9 at E5 ->
//    bcd_o=042 at E9; bcd_o=009 at E18 (7 overwritten); busy_o falls after E18.
//  6 SCAN_DIV=4: an_o sequence 1110,1101,1011,0111,1110, each held exactly 4 clocks.
//    Assert reset at E4 of a conversion -> all outputs at reset values immediately;
//    no commit follows after release.

Source files
------------

// File: rtl/output_display_driver.sv
// Display driver for the OUT register: sequential double-dabble BCD conversion of each
// loaded value, optional sign, and a 4-digit multiplexed common-anode 7-segment scan.
module output_display_driver #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SCAN_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  signed_i,
    output logic                  busy_o,
    output logic [11:0]           bcd_o,
    output logic                  neg_o,
    output logic [3:0]            an_o,
    output logic [6:0]            seg_o
);

    localparam int unsigned BW = 12;
    localparam int unsigned SW = BW + DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);
    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [6:0]  SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mag_q, mag_d;
    logic [BW-1:0]         work_q, work_d;
    logic                  neg_work_q, neg_work_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                  pend_signed_q, pend_signed_d;
    logic                  busy_q, busy_d;
    logic [BW-1:0]         bcd_q, bcd_d;
    logic                  neg_q, neg_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [1:0]            idx_q, idx_d;
    logic [3:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;

    logic [BW-1:0]         adj;
    logic [SW-1:0]         shifted;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? 4'(n + 4'd3) : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] d,
                                                        input logic sgn);
        return (sgn && d[DATA_WIDTH-1]) ? DATA_WIDTH'(~d + 1'b1) : d;
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (load_i) state_d = S_CONVERT;
            S_CONVERT: if (cnt_q == CW'(DATA_WIDTH - 1)) state_d = S_COMMIT;
            S_COMMIT:  state_d = (pend_valid_q || load_i) ? S_CONVERT : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        mag_d         = mag_q;
        work_d        = work_q;
        neg_work_d    = neg_work_q;
        cnt_d         = cnt_q;
        pend_valid_d  = pend_valid_q;
        pend_data_d   = pend_data_q;
        pend_signed_d = pend_signed_q;
        bcd_d         = bcd_q;
        neg_d         = neg_q;
        adj           = {add3(work_q[11:8]), add3(work_q[7:4]), add3(work_q[3:0])};
        shifted       = {adj, mag_q} << 1;

        case (state_q)
            S_IDLE: begin
                if (load_i) begin
                    mag_d      = magnitude(data_i, signed_i);
                    neg_work_d = signed_i && data_i[DATA_WIDTH-1];
                    work_d     = '0;
                    cnt_d      = '0;
                end
            end
            S_CONVERT: begin
                work_d = shifted[SW-1:DATA_WIDTH];
                mag_d  = shifted[DATA_WIDTH-1:0];
                cnt_d  = CW'(cnt_q + 1'b1);
                if (load_i) begin
                    pend_valid_d  = 1'b1;
                    pend_data_d   = data_i;
                    pend_signed_d = signed_i;
                end
            end
            S_COMMIT: begin
                bcd_d  = work_q;
                neg_d  = neg_work_q;
                work_d = '0;
                cnt_d  = '0;
                // A waiting value restarts first; a same-edge load then refills the slot
                if (pend_valid_q) begin
                    mag_d        = magnitude(pend_data_q, pend_signed_q);
                    neg_work_d   = pend_signed_q && pend_data_q[DATA_WIDTH-1];
                    pend_valid_d = load_i;
                    if (load_i) begin
                        pend_data_d   = data_i;
                        pend_signed_d = signed_i;
                    end
                end else if (load_i) begin
                    mag_d      = magnitude(data_i, signed_i);
                    neg_work_d = signed_i && data_i[DATA_WIDTH-1];
                end
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Scan prescaler, digit select and segment encoding
    always_comb begin
        presc_d = PW'(presc_q + 1'b1);
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = 2'(idx_q + 2'd1);
        end
        an_d = ~(4'b0001 << idx_q);
        case (idx_q)
            2'd0:    seg_d = seg7(bcd_q[3:0]);
            2'd1:    seg_d = (bcd_q[11:4] == 8'h00) ? SEG_BLANK : seg7(bcd_q[7:4]);
            2'd2:    seg_d = (bcd_q[11:8] == 4'h0) ? SEG_BLANK : seg7(bcd_q[11:8]);
            default: seg_d = neg_q ? SEG_MINUS : SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag_q         <= '0;
            work_q        <= '0;
            neg_work_q    <= 1'b0;
            cnt_q         <= '0;
            pend_valid_q  <= 1'b0;
            pend_data_q   <= '0;
            pend_signed_q <= 1'b0;
            busy_q        <= 1'b0;
            bcd_q         <= '0;
            neg_q         <= 1'b0;
            presc_q       <= '0;
            idx_q         <= '0;
            an_q          <= 4'b1111;
            seg_q         <= SEG_BLANK;
        end else begin
            mag_q         <= mag_d;
            work_q        <= work_d;
            neg_work_q    <= neg_work_d;
            cnt_q         <= cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_data_q   <= pend_data_d;
            pend_signed_q <= pend_signed_d;
            busy_q        <= busy_d;
            bcd_q         <= bcd_d;
            neg_q         <= neg_d;
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign busy_o = busy_q;
    assign bcd_o  = bcd_q;
    assign neg_o  = neg_q;
    assign an_o   = an_q;
    assign seg_o  = seg_q;

endmodule

// File: tb/tb_output_display_driver.sv
// Directed bench for output_display_driver: reset values, scan timing, BCD/sign
// conversion vectors, pending-load overwrite and reset abort mid-conversion.
module tb_output_display_driver;

    logic        clk;
    logic        reset;
    logic        load_i;
    logic [7:0]  data_i;
    logic        signed_i;
    logic        busy_o;
    logic [11:0] bcd_o;
    logic        neg_o;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;

    int checks = 0;
    int errors = 0;

    output_display_driver #(.DATA_WIDTH(8), .SCAN_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load_i),
        .data_i   (data_i),
        .signed_i (signed_i),
        .busy_o   (busy_o),
        .bcd_o    (bcd_o),
        .neg_o    (neg_o),
        .an_o     (an_o),
        .seg_o    (seg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        sgn;
        logic [11:0] bcd;
        logic        neg;
        logic [27:0] segs;   // {d3,d2,d1,d0}
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Starts at a negedge; returns at the first negedge with busy_o low
    task automatic do_load(input logic [7:0] d, input logic s, output int n);
        load_i = 1'b1; data_i = d; signed_i = s;
        @(negedge clk);
        load_i = 1'b0;
        n = 0;
        while (busy_o && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          n;
        logic [3:0]  ea;
        logic [27:0] sv;
        logic        found;

        vecs[0] = '{8'd1,   1'b0, 12'h001, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h79}};
        vecs[1] = '{8'hFF,  1'b0, 12'h255, 1'b0, {7'h7F, 7'h24, 7'h12, 7'h12}};
        vecs[2] = '{8'hFF,  1'b1, 12'h001, 1'b1, {7'h3F, 7'h7F, 7'h7F, 7'h79}};
        vecs[3] = '{8'h80,  1'b1, 12'h128, 1'b1, {7'h3F, 7'h79, 7'h24, 7'h00}};
        vecs[4] = '{8'd100, 1'b0, 12'h100, 1'b0, {7'h7F, 7'h79, 7'h40, 7'h40}};
        vecs[5] = '{8'd0,   1'b0, 12'h000, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[6] = '{8'hF6,  1'b1, 12'h010, 1'b1, {7'h3F, 7'h7F, 7'h79, 7'h40}};
        vecs[7] = '{8'd9,   1'b0, 12'h009, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h10}};
        vecs[8] = '{8'h7F,  1'b1, 12'h127, 1'b0, {7'h7F, 7'h79, 7'h24, 7'h78}};

        reset = 1'b0; load_i = 1'b0; data_i = '0; signed_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an",   32'(an_o),   32'hF);
        check("rst_seg",  32'(seg_o),  32'h7F);
        check("rst_bcd",  32'(bcd_o),  32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_neg",  32'(neg_o),  32'h0);

        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ea = ~(4'b0001 << ((i / 4) % 4));
            check($sformatf("scan_an[%0d]", i), 32'(an_o), 32'(ea));
            if (i == 0) check("first_seg", 32'(seg_o), 32'h40);
        end

        for (int v = 0; v < 9; v++) begin
            do_load(vecs[v].data, vecs[v].sgn, n);
            check($sformatf("v%0d_busy_cycles", v), 32'(n), 32'd9);
            check($sformatf("v%0d_bcd", v), 32'(bcd_o), 32'(vecs[v].bcd));
            check($sformatf("v%0d_neg", v), 32'(neg_o), 32'(vecs[v].neg));
            repeat (20) @(negedge clk);
            sv = vecs[v].segs;
            for (int k = 0; k < 4; k++) begin
                ea = ~(4'b0001 << k);
                found = 1'b0;
                for (int t = 0; t < 24 && !found; t++) begin
                    if (an_o == ea) found = 1'b1;
                    else @(negedge clk);
                end
                if (!found) check($sformatf("v%0d_d%0d_timeout", v, k), 32'(an_o), 32'(ea));
                else check($sformatf("v%0d_d%0d_seg", v, k), 32'(seg_o), 32'(sv[7*k +: 7]));
            end
        end

        // Loads at E0, E3, E5: 7 is overwritten by 9 in the pending slot
        for (int e = 0; e <= 20; e++) begin
            load_i = (e == 0 || e == 3 || e == 5);
            data_i = (e == 0) ? 8'd42 : (e == 3) ? 8'd7 : 8'd9;
            signed_i = 1'b0;
            @(negedge clk);
            load_i = 1'b0;
            if (e == 0)  check("pend_busy_e0", 32'(busy_o), 32'h1);
            if (e == 8)  check("pend_hold_e8", 32'(bcd_o), 32'h127);
            if (e == 9)  check("pend_bcd_e9", 32'(bcd_o), 32'h042);
            if (e == 9)  check("pend_busy_e9", 32'(busy_o), 32'h1);
            if (e == 17) check("pend_bcd_e17", 32'(bcd_o), 32'h042);
            if (e == 17) check("pend_busy_e17", 32'(busy_o), 32'h1);
            if (e == 18) check("pend_bcd_e18", 32'(bcd_o), 32'h009);
            if (e == 18) check("pend_busy_e18", 32'(busy_o), 32'h0);
            if (e == 20) check("pend_busy_e20", 32'(busy_o), 32'h0);
        end

        // Reset at E4 of a conversion that also has a pending load
        load_i = 1'b1; data_i = 8'd200; signed_i = 1'b0;
        @(negedge clk);
        load_i = 1'b0;
        @(negedge clk);
        load_i = 1'b1; data_i = 8'd50;
        @(negedge clk);
        load_i = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_an",   32'(an_o),   32'hF);
        check("abort_seg",  32'(seg_o),  32'h7F);
        check("abort_bcd",  32'(bcd_o),  32'h0);
        check("abort_busy", 32'(busy_o), 32'h0);
        check("abort_neg",  32'(neg_o),  32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("post_abort_busy[%0d]", i), 32'(busy_o), 32'h0);
        end
        check("post_abort_bcd", 32'(bcd_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
